spi_peripheral: RTL and testbench

SPI_PERIPHERAL -- requirements
Module: spi_peripheral

---
 rtl/spi_peripheral.sv | 116 +++++++++++
 tb/tb_spi_peripheral.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/spi_peripheral.sv
// spi_peripheral: SPI mode-0 peripheral writing five 8-bit registers from 16-bit R/W+addr+data frames.
// Define SPI_READBACK_EN to return the addressed register on cipo during read frames.
module spi_peripheral #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [6:0] MAX_ADDR    = 7'h04
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic       cipo,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       wr_done
);
    logic [SYNC_STAGES-1:0] sclk_s, copi_s, ncs_s, flush;
    logic                   sclk_d, ncs_d, armed, active;
    logic                   sclk_q, copi_q, ncs_q, sclk_rise, ncs_fall, ncs_rise, commit;
    logic [15:0]            shreg;
    logic [4:0]             cnt;
    logic [4:0][7:0]        regs;

    assign sclk_q    = sclk_s[SYNC_STAGES-1];
    assign copi_q    = copi_s[SYNC_STAGES-1];
    assign ncs_q     = ncs_s[SYNC_STAGES-1];
    assign sclk_rise = sclk_q & ~sclk_d & ~ncs_q & active;
    // A frame only starts once ncs has been seen high after reset, so a frame cut by reset is skipped.
    assign ncs_fall  = ~ncs_q & ncs_d & armed;
    assign ncs_rise  = ncs_q & ~ncs_d;
    assign commit    = ncs_rise & active & (cnt == 5'd16) & shreg[15]
                     & (shreg[14:8] <= MAX_ADDR) & (shreg[14:8] < 7'd5);

    assign en_reg_out_7_0  = regs[0];
    assign en_reg_out_15_8 = regs[1];
    assign en_reg_pwm_7_0  = regs[2];
    assign en_reg_pwm_15_8 = regs[3];
    assign pwm_duty_cycle  = regs[4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_s  <= '0;
            copi_s  <= '0;
            ncs_s   <= '1;
            flush   <= '0;
            sclk_d  <= 1'b0;
            ncs_d   <= 1'b1;
            armed   <= 1'b0;
            active  <= 1'b0;
            shreg   <= '0;
            cnt     <= '0;
            regs    <= '0;
            wr_done <= 1'b0;
        end else begin
            sclk_s  <= {sclk_s[SYNC_STAGES-2:0], sclk};
            copi_s  <= {copi_s[SYNC_STAGES-2:0], copi};
            ncs_s   <= {ncs_s[SYNC_STAGES-2:0], ncs};
            flush   <= {flush[SYNC_STAGES-2:0], 1'b1};
            sclk_d  <= sclk_q;
            ncs_d   <= ncs_q;
            armed   <= armed | (flush[SYNC_STAGES-1] & ncs_q);
            wr_done <= commit;
            if (ncs_fall) begin
                active <= 1'b1;
                shreg  <= '0;
                cnt    <= '0;
            end else if (sclk_rise && cnt != 5'd16) begin
                shreg <= {shreg[14:0], copi_q};
                cnt   <= cnt + 5'd1;
            end
            if (ncs_rise)
                active <= 1'b0;
            for (int i = 0; i < 5; i++)
                if (commit && shreg[14:8] == 7'(i))
                    regs[i] <= shreg[7:0];
        end
    end

`ifdef SPI_READBACK_EN
    logic       sclk_fall, rd;
    logic [7:0] tx, rd_val;

    assign sclk_fall = ~sclk_q & sclk_d & ~ncs_q & active;

    always_comb begin
        rd_val = '0;
        for (int i = 0; i < 5; i++)
            if (shreg[6:0] == 7'(i) && shreg[6:0] <= MAX_ADDR)
                rd_val = regs[i];
    end

    // After 8 bits the R/W flag sits in shreg[7] and the address in shreg[6:0].
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cipo <= 1'b0;
            tx   <= '0;
            rd   <= 1'b0;
        end else if (ncs_q) begin
            cipo <= 1'b0;
            rd   <= 1'b0;
        end else if (sclk_fall && cnt == 5'd8 && !shreg[7]) begin
            cipo <= rd_val[7];
            tx   <= {rd_val[6:0], 1'b0};
            rd   <= 1'b1;
        end else if (sclk_fall && rd && cnt < 5'd16) begin
            cipo <= tx[7];
            tx   <= {tx[6:0], 1'b0};
        end
    end
`else
    assign cipo = 1'b0;
`endif
endmodule

// File: tb/tb_spi_peripheral.sv
// tb_spi_peripheral: randomized self-checking bench for spi_peripheral against a register-map model.
module tb_spi_peripheral;
    logic       clk = 1'b0, rst_n = 1'b0, sclk = 1'b0, copi = 1'b0, ncs = 1'b1;
    logic       cipo, wr_done;
    logic [7:0] r0, r1, r2, r3, r4;
    logic [7:0] model [5];
    int         exp_wr = 0, wr_cnt = 0, checks = 0, errors = 0;
`ifdef SPI_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    spi_peripheral dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .copi(copi), .ncs(ncs), .cipo(cipo),
        .en_reg_out_7_0(r0), .en_reg_out_15_8(r1), .en_reg_pwm_7_0(r2),
        .en_reg_pwm_15_8(r3), .pwm_duty_cycle(r4), .wr_done(wr_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (wr_done) wr_cnt++;

    function automatic logic [7:0] dut_reg(int i);
        return i == 0 ? r0 : i == 1 ? r1 : i == 2 ? r2 : i == 3 ? r3 : r4;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b, output logic s);
        copi = b;
        tick(4);
        s = cipo;
        sclk = 1'b1;
        tick(4);
        sclk = 1'b0;
    endtask

    task automatic spi_frame(input logic [15:0] word, input int nbits, input int gap, output logic [7:0] rx);
        logic s;
        rx = '0;
        ncs = 1'b0;
        tick(4);
        for (int i = 0; i < nbits; i++) begin
            send_bit(i < 16 ? word[15-i] : 1'($urandom), s);
            if (i >= 8 && i < 16) rx = {rx[6:0], s};
        end
        tick(4);
        ncs = 1'b1;
        tick(gap);
    endtask

    // Spec rule: a complete (>=16 bit) write frame to an address 0..4 updates that one register.
    task automatic model_frame(input logic [15:0] word, input int nbits);
        if (nbits >= 16 && word[15] && word[14:8] <= 7'd4) begin
            model[word[14:8]] = word[7:0];
            exp_wr++;
        end
    endtask

    task automatic test_reset;
        tick(3);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (dut_reg(i) !== 8'h00) begin errors++; $display("FAIL reset reg%0d: got %h expected 00", i, dut_reg(i)); end
            model[i] = 8'h00;
        end
        checks++;
        if (wr_done !== 1'b0 || cipo !== 1'b0) begin errors++; $display("FAIL reset outs: wr_done=%b cipo=%b expected 0 0", wr_done, cipo); end
        rst_n = 1'b1;
        tick(8);
    endtask

    task automatic test_write(input string tag, input logic [15:0] word, input int nbits);
        logic [7:0] rx;
        spi_frame(word, nbits, 8, rx);
        model_frame(word, nbits);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (dut_reg(i) !== model[i]) begin errors++; $display("FAIL %s reg%0d: got %h expected %h", tag, i, dut_reg(i), model[i]); end
        end
        checks++;
        if (wr_cnt !== exp_wr) begin errors++; $display("FAIL %s wr_done count: got %0d expected %0d", tag, wr_cnt, exp_wr); end
    endtask

    task automatic test_mid_reset;
        logic s;
        ncs = 1'b0;
        tick(4);
        for (int i = 0; i < 10; i++) send_bit(i == 0 ? 1'b1 : 1'($urandom), s);
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (dut_reg(i) !== 8'h00) begin errors++; $display("FAIL mid_reset async reg%0d: got %h expected 00", i, dut_reg(i)); end
            model[i] = 8'h00;
        end
        tick(2);
        rst_n = 1'b1;
        for (int i = 10; i < 16; i++) send_bit(1'($urandom), s);
        tick(4);
        ncs = 1'b1;
        tick(8);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (dut_reg(i) !== 8'h00) begin errors++; $display("FAIL mid_reset reg%0d: got %h expected 00", i, dut_reg(i)); end
        end
        checks++;
        if (wr_cnt !== exp_wr) begin errors++; $display("FAIL mid_reset wr_done count: got %0d expected %0d", wr_cnt, exp_wr); end
    endtask

    task automatic test_back_to_back;
        logic [15:0] w [3];
        logic [7:0]  rx;
        int          gaps [3] = '{1, 3, 8};
        for (int k = 0; k < 3; k++) begin
            w[k] = {1'b1, 7'($urandom_range(0, 4)), 8'($urandom)};
            spi_frame(w[k], 16, gaps[k], rx);
            model_frame(w[k], 16);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (dut_reg(i) !== model[i]) begin errors++; $display("FAIL back_to_back reg%0d: got %h expected %h", i, dut_reg(i), model[i]); end
        end
        checks++;
        if (wr_cnt !== exp_wr) begin errors++; $display("FAIL back_to_back wr_done count: got %0d expected %0d", wr_cnt, exp_wr); end
    endtask

    task automatic test_readback;
        logic [7:0] rx;
        spi_frame(16'h833C, 16, 8, rx);
        model_frame(16'h833C, 16);
        spi_frame(16'h0300, 16, 8, rx);
        checks++;
        if (rx !== (RB ? 8'h3C : 8'h00)) begin errors++; $display("FAIL readback addr3: got %h expected %h", rx, RB ? 8'h3C : 8'h00); end
        spi_frame(16'h0500, 16, 8, rx);
        checks++;
        if (rx !== 8'h00) begin errors++; $display("FAIL readback addr5: got %h expected 00", rx); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (dut_reg(i) !== model[i]) begin errors++; $display("FAIL readback reg%0d: got %h expected %h", i, dut_reg(i), model[i]); end
        end
        checks++;
        if (wr_cnt !== exp_wr || cipo !== 1'b0) begin errors++; $display("FAIL readback wr/cipo: got %0d/%b expected %0d/0", wr_cnt, cipo, exp_wr); end
    endtask

    task automatic test_random;
        logic [15:0] w;
        logic [7:0]  rx, exp_rx;
        int          n;
        for (int k = 0; k < 30; k++) begin
            w = {1'($urandom), 7'($urandom_range(0, 6)), 8'($urandom)};
            n = $urandom_range(15, 17);
            exp_rx = (RB && !w[15] && w[14:8] <= 7'd4) ? model[w[14:8]] : 8'h00;
            spi_frame(w, n, 8, rx);
            model_frame(w, n);
            if (n >= 16 && !w[15]) begin
                checks++;
                if (rx !== exp_rx) begin errors++; $display("FAIL random read %h: got %h expected %h", w, rx, exp_rx); end
            end
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (dut_reg(i) !== model[i]) begin errors++; $display("FAIL random %h/%0d reg%0d: got %h expected %h", w, n, i, dut_reg(i), model[i]); end
            end
            checks++;
            if (wr_cnt !== exp_wr || cipo !== 1'b0) begin errors++; $display("FAIL random %h/%0d wr/cipo: got %0d/%b expected %0d/0", w, n, wr_cnt, cipo, exp_wr); end
        end
    endtask

    initial begin
        test_reset;
        test_write("write_ff_a0", 16'h80FF, 16);
        test_write("write_80_a4", 16'h8480, 16);
        test_write("write_01_a2", 16'h8201, 16);
        test_write("short_15", 16'h81AA, 15);
        test_write("long_17", 16'h81AA, 17);
        test_write("bad_addr5", 16'h8555, 16);
        test_mid_reset;
        test_write("after_reset", 16'h825A, 16);
        test_back_to_back;
        test_readback;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
